// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and width helpers for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_STALL} arb_state_t;

  // Index width for a range of n values, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-facing signal bundle of the write arbiter.
interface fifo_write_arbiter_if #(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0]            last;
  logic [N_REQ*DATA_WIDTH-1:0] wdata;
  logic                        fifo_full;
  logic [N_REQ-1:0]            gnt;
  logic                        fifo_write;
  logic [DATA_WIDTH-1:0]       fifo_wdata;
  logic                        busy;
  logic                        stalled;

  modport master (
    output req, last, wdata, fifo_full,
    input  gnt, fifo_write, fifo_wdata, busy, stalled
  );

  modport slave (
    input  req, last, wdata, fifo_full,
    output gnt, fifo_write, fifo_wdata, busy, stalled
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo N_REQ.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]                  req,
  input  logic [idx_width(N_REQ)-1:0]       ptr,
  output logic                              found,
  output logic [idx_width(N_REQ)-1:0]       idx
);

  localparam int unsigned PW = idx_width(N_REQ);

  always_comb begin
    int unsigned j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = (32'(ptr) + k) % N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin FIFO write-port arbiter with capped, lockable multi-beat bursts.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 8
) (
  input logic                 clk,
  input logic                 reset,
  fifo_write_arbiter_if.slave bus
);

  localparam int unsigned PW = idx_width(N_REQ);
  localparam int unsigned CW = idx_width(MAX_BURST + 1);

  arb_state_t      state, state_d;
  logic [PW-1:0]   owner, owner_d;
  logic [PW-1:0]   ptr, ptr_d;
  logic [CW-1:0]   beat_cnt, beat_cnt_d;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [CW-1:0]   cnt_inc;
  logic [N_REQ-1:0] gnt_c;
  logic [DATA_WIDTH-1:0] wdata_c;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cnt_inc = beat_cnt + CW'(1);

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == PW'(N_REQ - 1)) ? '0 : i + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      owner    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      owner    <= owner_d;
      ptr      <= ptr_d;
      beat_cnt <= beat_cnt_d;
    end
  end

  // Next state and zero-latency grant; grants are suppressed while reset is held.
  always_comb begin
    state_d    = state;
    owner_d    = owner;
    ptr_d      = ptr;
    beat_cnt_d = beat_cnt;
    gnt_c      = '0;
    unique case (state)
      S_IDLE: begin
        if (pick_found && !bus.fifo_full) begin
          gnt_c[pick_idx] = 1'b1;
          if (bus.last[pick_idx] || (MAX_BURST == 1)) begin
            ptr_d = next_idx(pick_idx);
          end else begin
            state_d    = S_BURST;
            owner_d    = pick_idx;
            beat_cnt_d = CW'(1);
          end
        end
      end
      S_BURST: begin
        if (bus.fifo_full) begin
          state_d = S_STALL;
        end else if (bus.req[owner]) begin
          gnt_c[owner] = 1'b1;
          if (bus.last[owner] || (cnt_inc == CW'(MAX_BURST))) begin
            state_d    = S_IDLE;
            ptr_d      = next_idx(owner);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = cnt_inc;
          end
        end
      end
      S_STALL: begin
        if (!bus.fifo_full) state_d = S_BURST;
      end
      default: state_d = S_IDLE;
    endcase
    if (!reset) gnt_c = '0;
  end

  // One-hot grant selects the write word.
  always_comb begin
    wdata_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_c[i]) wdata_c = wdata_c | bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign bus.gnt        = gnt_c;
  assign bus.fifo_write = |gnt_c;
  assign bus.fifo_wdata = wdata_c;
  assign bus.busy       = (state != S_IDLE);
  assign bus.stalled    = (state == S_STALL);

endmodule
